// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers
//   clk/clrn        : clock, asynchronous active-low reset
//   start, op       : launch MULTU(00)/MULT(01)/DIVU(10)/DIV(11) from IDLE
//   a, b            : rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we    : MTHI/MTLO write strobes for wdata, honoured only in IDLE
//   busy, done      : operation in progress / one-cycle result-ready pulse
//   hi, lo          : HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0] opnd_q, hi_q, lo_q, hi_d, lo_d, abs_a, abs_b;
    logic div_q, sa_q, neg_q, dz_q, done_q, sa, sb, ge;
    logic [WIDTH:0] sum, rem_t;
    assign sa = op[0] & a[WIDTH-1];
    assign sb = op[0] & b[WIDTH-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;
    // acc_q holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; opnd_q is the addend/divisor.
    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_t = acc_q[2*WIDTH-1:WIDTH-1];
        // a compare (not a borrow bit) keeps divide-by-zero producing all-ones
        ge = rem_t >= {1'b0, opnd_q};
        acc_d = div_q ? {ge ? WIDTH'(rem_t - {1'b0, opnd_q}) : rem_t[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                      : (acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]});
        prod = neg_q ? -acc_q : acc_q;
        // remainder follows the dividend sign; for divide-by-zero this restores raw a
        hi_d = div_q ? (sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
        lo_d = div_q ? ((neg_q & ~dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[WIDTH-1:0];
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            opnd_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            div_q <= 1'b0;
            sa_q <= 1'b0;
            neg_q <= 1'b0;
            dz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        div_q <= op[1];
                        sa_q <= sa;
                        neg_q <= sa ^ sb;
                        dz_q <= b == '0;
                        acc_q <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                        opnd_q <= op[1] ? abs_b : abs_a;
                        cnt_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIN;
                end
                FIN: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    done_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;
    logic clk = 1'b0, clrn = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0] op = 2'd0;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic busy, done;
    logic [W-1:0] hi, lo;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );
    // Reference: plain arithmetic on the architectural definitions, returns {hi, lo}
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'd0: return {32'b0, x} * {32'b0, y};
            2'd1: begin
                p = 64'(sx) * 64'(sy);
                return p;
            end
            2'd2: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction
    // Launch one op at the current negedge and wait (bounded) for done; no checking here
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl, output int cyc);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        cyc = 0;
        for (int n = 0; n < 50 && done !== 1'b1; n++) begin
            if (busy === 1'b1) cyc++;
            @(negedge clk);
        end
        rh = hi; rl = lo;
    endtask
    task automatic test_reset;
        #1 clrn = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        clrn = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_mthi_mtlo;
        hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0;
        @(negedge clk);
        lo_we = 1'b0;
        checks += 3;
        if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi got=%h exp=%h", hi, 32'h12345678); end
        if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo got=%h exp=%h", lo, 32'h9ABCDEF0); end
        if (done !== 1'b0) begin failures++; $display("FAIL mt_done got=%b exp=0", done); end
    endtask
    task automatic test_multu;
        logic [31:0] rh, rl;
        int cyc;
        do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, cyc);
        checks += 3;
        if (cyc !== 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", cyc); end
        if (rh !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=%h", rh, 32'hFFFFFFFE); end
        if (rl !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=%h", rl, 32'h1); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_done got=%b exp=0", busy); end
    endtask
    task automatic test_back_to_back;
        logic [31:0] rh, rl;
        int cyc;
        do_op(2'd1, 32'hFFFFFFFD, 32'd7, rh, rl, cyc);
        checks += 3;
        if (cyc !== 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", cyc); end
        if (rh !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=%h", rh, 32'hFFFFFFFF); end
        if (rl !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=%h", rl, 32'hFFFFFFEB); end
        do_op(2'd1, 32'h80000000, 32'h80000000, rh, rl, cyc);
        checks += 3;
        if (cyc !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", cyc); end
        if (rh !== 32'h40000000) begin failures++; $display("FAIL b2b_hi got=%h exp=%h", rh, 32'h40000000); end
        if (rl !== 32'h0) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", rl, 32'h0); end
        @(negedge clk);
    endtask
    task automatic test_div_with_write;
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA5555;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks += 2;
        if (hi !== 32'hAAAA5555) begin failures++; $display("FAIL start_write_hi got=%h exp=%h", hi, 32'hAAAA5555); end
        if (lo !== 32'hAAAA5555) begin failures++; $display("FAIL start_write_lo got=%h exp=%h", lo, 32'hAAAA5555); end
        for (int n = 0; n < 50 && done !== 1'b1; n++) @(negedge clk);
        checks += 2;
        if (lo !== 32'd14) begin failures++; $display("FAIL divu_q got=%h exp=%h", lo, 32'd14); end
        if (hi !== 32'd2) begin failures++; $display("FAIL divu_r got=%h exp=%h", hi, 32'd2); end
        @(negedge clk);
    endtask
    task automatic test_div_signed;
        logic [31:0] rh, rl;
        int cyc;
        do_op(2'd3, 32'hFFFFFFF9, 32'd2, rh, rl, cyc);
        checks += 2;
        if (rl !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_q got=%h exp=%h", rl, 32'hFFFFFFFD); end
        if (rh !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_r got=%h exp=%h", rh, 32'hFFFFFFFF); end
        do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, rh, rl, cyc);
        checks += 3;
        if (rl !== 32'h80000000) begin failures++; $display("FAIL div_ovf_q got=%h exp=%h", rl, 32'h80000000); end
        if (rh !== 32'h0) begin failures++; $display("FAIL div_ovf_r got=%h exp=%h", rh, 32'h0); end
        if (cyc !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", cyc); end
        @(negedge clk);
    endtask
    task automatic test_divzero_busy_ignore;
        int cyc;
        op = 2'd2; a = 32'h00001234; b = 32'h0; start = 1'b1;
        cyc = 0;
        for (int n = 0; n < 50 && done !== 1'b1; n++) begin
            @(negedge clk);
            if (busy === 1'b1) cyc++;
            start = (n == 5);
            hi_we = (n == 5);
            wdata = 32'hCAFEF00D;
            op = 2'($urandom); a = $urandom; b = $urandom;
        end
        start = 1'b0; hi_we = 1'b0;
        checks += 3;
        if (cyc !== 33) begin failures++; $display("FAIL divzero_latency got=%0d exp=33", cyc); end
        if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divzero_q got=%h exp=%h", lo, 32'hFFFFFFFF); end
        if (hi !== 32'h00001234) begin failures++; $display("FAIL divzero_r got=%h exp=%h", hi, 32'h1234); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued got=%b exp=0", busy); end
    endtask
    task automatic test_random;
        logic [31:0] rh, rl, x, y;
        logic [1:0] o;
        logic [63:0] exp_v;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 100)) : $urandom);
            if ($urandom_range(0, 9) == 0) y = 32'hFFFFFFFF;
            exp_v = ref_model(o, x, y);
            do_op(o, x, y, rh, rl, cyc);
            checks += 2;
            if ({rh, rl} !== exp_v) begin
                failures++;
                $display("FAIL rand_result op=%0d a=%h b=%h got=%h_%h exp=%h_%h", o, x, y, rh, rl, exp_v[63:32], exp_v[31:0]);
            end
            if (cyc !== 33) begin failures++; $display("FAIL rand_latency got=%0d exp=33", cyc); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask
    task automatic test_reset_midop;
        int seen;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; a = 32'hFFFFFFFF; b = 32'h12345; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        if (hi !== 32'h0) begin failures++; $display("FAIL midreset_hi got=%h exp=%h", hi, 32'h0); end
        if (lo !== 32'h0) begin failures++; $display("FAIL midreset_lo got=%h exp=%h", lo, 32'h0); end
        @(negedge clk);
        clrn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL midreset_no_result got=%0d exp=0", seen); end
    endtask
    initial begin
        test_reset;
        test_mthi_mtlo;
        test_multu;
        test_back_to_back;
        test_div_with_write;
        test_div_signed;
        test_divzero_busy_ignore;
        test_random;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the 32x32 register file: operands come from read ports A/B (rs/rt) and results land in HI/LO for MFHI/MFLO.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises busy so the control unit stalls the pipeline while an operation runs.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each, product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  launch the operation selected by op; sampled only in IDLE
op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
a  input  WIDTH  operand rs (regfile qa); dividend or multiplicand
b  input  WIDTH  operand rt (regfile qb); divisor or multiplier
hi_we  input  1  MTHI: write wdata to HI
lo_we  input  1  MTLO: write wdata to LO
wdata  input  WIDTH  data for MTHI/MTLO (regfile qa)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: HI/LO hold a new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: clk and reset are clk and clrn, asynchronous, active-low. On clrn=0, immediately and regardless of state: state=IDLE, busy=0, done=0, hi=0, lo=0, counter and working registers cleared. An operation interrupted by reset is abandoned and produces no result.
- FSM states: IDLE, RUN, FIN. busy = (state != IDLE).
- IDLE, start=1 (edge t0):
  - Capture |a|, |b|, sign(a), sign(b) and op.
  - Magnitudes are taken only for signed ops (op[0]=1); unsigned ops take a and b raw.
  - counter=0, state goes to RUN.
- RUN: one radix-2 iteration per clock for WIDTH clocks (edges t0+1 to t0+WIDTH). After the last iteration, state goes to FIN.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division producing a WIDTH-bit quotient and remainder.
- FIN (edge t0+WIDTH+1): HI/LO written, done registered high for exactly the following cycle, state goes to IDLE.
- Latency: busy is high for WIDTH+1 cycles after start (33 for WIDTH=32). New HI/LO values are visible in the same cycle done=1. A new start is accepted in that same done cycle.
- Multiply results: {hi,lo} = product. For MULT with sign(a)^sign(b), the 2*WIDTH product is two's-complement negated.
- Divide results: lo = quotient, hi = remainder.
  - DIV quotient is negated if sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b==0, DIV or DIVU): same latency; lo=all ones, hi=a (raw operand); no sign correction.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - In IDLE: the register is written with wdata at the edge. Both may be asserted together.
  - Write together with start: the write takes effect; the later result overwrites it.
  - While busy: ignored.
- done=1 only in the cycle following FIN; it is never asserted for MTHI/MTLO.
- Operands a/b may change after the start edge without affecting the result.

Test Plan:
1. Reset then idle: clrn=0 pulse -> hi=0, lo=0, busy=0, done=0. MTHI wdata=0x12345678 and MTLO wdata=0x9ABCDEF0 in IDLE -> hi=0x12345678, lo=0x9ABCDEF0 the next cycle.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 33 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
3. MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back start in the done cycle: MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
4. DIVU 100 / 7 -> lo=0x0000000E, hi=0x00000002. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
5. DIVU 0x00001234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234, 33-cycle latency. Also: start and hi_we pulsed while busy -> ignored, result unchanged.
6. Reset mid-op: start MULTU, assert clrn=0 at cycle 10 -> busy=0, hi=lo=0 immediately, and no done pulse after release.
